// File: rtl/axil_regfile_gen2.sv
// AXI4-Lite slave register file. Width, depth and read-only (hardware-fed) slots
// are parameters. AW and W are captured independently, WSTRB selects bytes, bad
// addresses answer DECERR, writes to read-only slots answer SLVERR, and every
// successful access raises a one-cycle per-register strobe toward user logic.
//
// Handshake rule on every channel: a beat transfers on the rising ACLK edge where
// VALID and READY are both high; the sender keeps VALID and payload stable until then.
module axil_regfile_gen2 #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_REGS    = 8,
    parameter int                    ADDR_WIDTH  = 8,
    parameter logic [NUM_REGS-1:0]   RO_MASK     = '0,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                           ACLK,
    input  logic                           ARESETN,
    input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                     S_AXI_AWPROT,
    input  logic                           S_AXI_AWVALID,
    output logic                           S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                           S_AXI_WVALID,
    output logic                           S_AXI_WREADY,
    output logic [1:0]                     S_AXI_BRESP,
    output logic                           S_AXI_BVALID,
    input  logic                           S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                     S_AXI_ARPROT,
    input  logic                           S_AXI_ARVALID,
    output logic                           S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                     S_AXI_RRESP,
    output logic                           S_AXI_RVALID,
    input  logic                           S_AXI_RREADY,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_in,
    output logic [NUM_REGS-1:0]            wr_pulse,
    output logic [NUM_REGS-1:0]            rd_pulse,
    output logic [1:0]                     dbg_wr_state_o,
    output logic                           dbg_rd_state_o
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int IDX_W  = ADDR_WIDTH - LSB;

    typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} wr_state_e;
    typedef enum logic {R_IDLE, R_RESP} rd_state_e;

    // Response code for an index: DECERR outside the map, SLVERR for writes to RO slots.
    function automatic logic [1:0] decode_resp(input logic [IDX_W-1:0] idx, input logic is_write);
        logic [1:0] resp;
        resp = 2'b11;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx == IDX_W'(i)) resp = (is_write && RO_MASK[i]) ? 2'b10 : 2'b00;
        end
        return resp;
    endfunction

    wr_state_e                          wr_state_q, wr_state_d;
    rd_state_e                          rd_state_q, rd_state_d;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q;
    logic [IDX_W-1:0]                   aw_idx_q;
    logic [DATA_WIDTH-1:0]              wdata_q;
    logic [STRB_W-1:0]                  wstrb_q;
    logic [1:0]                         bresp_q, rresp_q;
    logic [DATA_WIDTH-1:0]              rdata_q, rd_val_d;
    logic [NUM_REGS-1:0]                wr_pulse_q, wr_pulse_d, rd_pulse_q, rd_pulse_d;
    logic [NUM_REGS-1:0]                wr_hit, rd_hit;

    logic [IDX_W-1:0]      aw_idx_in, ar_idx_in, cm_idx;
    logic [DATA_WIDTH-1:0] cm_data;
    logic [STRB_W-1:0]     cm_strb;
    logic [1:0]            cm_resp, ar_resp;
    logic                  aw_hs, w_hs, ar_hs, wr_commit, wr_ok;
    logic                  unused_bits;

    assign aw_idx_in = S_AXI_AWADDR[ADDR_WIDTH-1:LSB];
    assign ar_idx_in = S_AXI_ARADDR[ADDR_WIDTH-1:LSB];
    assign aw_hs     = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs      = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs     = S_AXI_ARVALID && S_AXI_ARREADY;

    // The write commits on whichever edge completes the second of the two handshakes;
    // the half that arrived earlier comes from the capture registers.
    assign wr_commit = (wr_state_q == W_IDLE && aw_hs && w_hs) ||
                       (wr_state_q == W_HAVE_ADDR && w_hs) ||
                       (wr_state_q == W_HAVE_DATA && aw_hs);
    assign cm_idx    = (wr_state_q == W_HAVE_ADDR) ? aw_idx_q : aw_idx_in;
    assign cm_data   = (wr_state_q == W_HAVE_DATA) ? wdata_q : S_AXI_WDATA;
    assign cm_strb   = (wr_state_q == W_HAVE_DATA) ? wstrb_q : S_AXI_WSTRB;
    assign cm_resp   = decode_resp(cm_idx, 1'b1);
    assign wr_ok     = wr_commit && (cm_resp == 2'b00);
    assign ar_resp   = decode_resp(ar_idx_in, 1'b0);

    // Write FSM state register.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) wr_state_q <= W_IDLE;
        else          wr_state_q <= wr_state_d;
    end

    // Write FSM next state: AW and W may land in either order or together.
    always_comb begin
        wr_state_d = wr_state_q;
        unique case (wr_state_q)
            W_IDLE: begin
                if (aw_hs && w_hs) wr_state_d = W_RESP;
                else if (aw_hs)    wr_state_d = W_HAVE_ADDR;
                else if (w_hs)     wr_state_d = W_HAVE_DATA;
            end
            W_HAVE_ADDR: if (w_hs)          wr_state_d = W_RESP;
            W_HAVE_DATA: if (aw_hs)         wr_state_d = W_RESP;
            W_RESP:      if (S_AXI_BREADY)  wr_state_d = W_IDLE;
        endcase
    end

    // Write FSM outputs; READYs are held low while reset is asserted.
    always_comb begin
        S_AXI_AWREADY = 1'b0;
        S_AXI_WREADY  = 1'b0;
        S_AXI_BVALID  = 1'b0;
        unique case (wr_state_q)
            W_IDLE: begin
                S_AXI_AWREADY = ARESETN;
                S_AXI_WREADY  = ARESETN;
            end
            W_HAVE_ADDR: S_AXI_WREADY  = ARESETN;
            W_HAVE_DATA: S_AXI_AWREADY = ARESETN;
            W_RESP:      S_AXI_BVALID  = 1'b1;
        endcase
    end

    // One-hot register selects for the committing write and the accepted read.
    always_comb begin
        wr_hit   = '0;
        rd_hit   = '0;
        rd_val_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_hit[i] = (cm_idx == IDX_W'(i));
            if (ar_idx_in == IDX_W'(i)) begin
                rd_hit[i] = 1'b1;
                rd_val_d  = RO_MASK[i] ? reg_in[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
            end
        end
        wr_pulse_d = wr_ok ? wr_hit : '0;
        rd_pulse_d = (ar_hs && ar_resp == 2'b00) ? rd_hit : '0;
    end

    // Capture the early half of a write and register the B response and write strobe.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_idx_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= 2'b00;
            wr_pulse_q <= '0;
        end else begin
            if (aw_hs) aw_idx_q <= aw_idx_in;
            if (w_hs) begin
                wdata_q <= S_AXI_WDATA;
                wstrb_q <= S_AXI_WSTRB;
            end
            if (wr_commit) bresp_q <= cm_resp;
            wr_pulse_q <= wr_pulse_d;
        end
    end

    // Register storage: only enabled bytes of an OKAY write change.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            regs_q <= {NUM_REGS{RESET_VALUE}};
        end else if (wr_ok) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                for (int k = 0; k < STRB_W; k++) begin
                    if (wr_hit[i] && cm_strb[k]) regs_q[i][k*8 +: 8] <= cm_data[k*8 +: 8];
                end
            end
        end
    end

    // Read FSM state register.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) rd_state_q <= R_IDLE;
        else          rd_state_q <= rd_state_d;
    end

    // Read FSM next state.
    always_comb begin
        rd_state_d = rd_state_q;
        unique case (rd_state_q)
            R_IDLE: if (ar_hs)        rd_state_d = R_RESP;
            R_RESP: if (S_AXI_RREADY) rd_state_d = R_IDLE;
        endcase
    end

    // Read FSM outputs.
    always_comb begin
        S_AXI_ARREADY = (rd_state_q == R_IDLE) && ARESETN;
        S_AXI_RVALID  = (rd_state_q == R_RESP);
    end

    // Read data path: sampled at the AR handshake (pre-write value on a same-edge commit).
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rdata_q    <= '0;
            rresp_q    <= 2'b00;
            rd_pulse_q <= '0;
        end else begin
            if (ar_hs) begin
                rdata_q <= rd_val_d;
                rresp_q <= ar_resp;
            end
            rd_pulse_q <= rd_pulse_d;
        end
    end

    // Flattened register view; RO slots reflect the hardware input directly.
    always_comb begin
        reg_out = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_out[i*DATA_WIDTH +: DATA_WIDTH] =
                RO_MASK[i] ? reg_in[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
        end
    end

    assign S_AXI_BRESP    = bresp_q;
    assign S_AXI_RDATA    = rdata_q;
    assign S_AXI_RRESP    = rresp_q;
    assign wr_pulse       = wr_pulse_q;
    assign rd_pulse       = rd_pulse_q;
    assign dbg_wr_state_o = wr_state_q;
    assign dbg_rd_state_o = rd_state_q;

    // PROT and sub-word address bits carry no meaning here.
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[LSB-1:0],
                           S_AXI_ARADDR[LSB-1:0], reg_in, regs_q};
endmodule

// File: doc/axil_regfile_gen2.md
Name: axil_regfile_gen2

Overview:
Parametrised AXI4-Lite slave register file, the successor to the fixed 4-register peripheral slave.
- Generalised: data width, register count, per-register read-only (hardware-fed) mask.
- Adds independent AW/W acceptance, WSTRB byte enables, DECERR/SLVERR responses, and per-register write/read strobes to user logic.
- Sits between the AXI interconnect (or master VIP in bench) and peripheral cores such as the I2C engine.

Parameters:
DATA_WIDTH, 32, bus and register width; 32 or 64 only.
NUM_REGS, 8, number of registers; 2..64.
ADDR_WIDTH, 8, AXI address width; must be >= clog2(NUM_REGS)+clog2(DATA_WIDTH/8).
RO_MASK, 0, NUM_REGS-bit mask; bit i=1 makes register i read-only, sourced from reg_in.
RESET_VALUE, 0, DATA_WIDTH reset value of every RW register.

Ports:
ACLK  in  1  clock
ARESETN  in  1  asynchronous active-low reset
S_AXI_AWADDR  in  ADDR_WIDTH  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  AW handshake
S_AXI_WDATA  in  DATA_WIDTH  write data
S_AXI_WSTRB  in  DATA_WIDTH/8  byte enables
S_AXI_WVALID / S_AXI_WREADY  in/out  1  W handshake
S_AXI_BRESP  out  2  write response
S_AXI_BVALID / S_AXI_BREADY  out/in  1  B handshake
S_AXI_ARADDR  in  ADDR_WIDTH  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  AR handshake
S_AXI_RDATA  out  DATA_WIDTH  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID / S_AXI_RREADY  out/in  1  R handshake
reg_out  out  NUM_REGS*DATA_WIDTH  flattened register contents; reg i at [i*DW +: DW]; RO slots drive reg_in slice
reg_in  in  NUM_REGS*DATA_WIDTH  hardware values for RO registers; RW slots ignored
wr_pulse  out  NUM_REGS  one-cycle strobe per successful write
rd_pulse  out  NUM_REGS  one-cycle strobe per successful read

Behaviour:
Decode:
- LSB = clog2(DATA_WIDTH/8); index = ADDR[ADDR_WIDTH-1:LSB]; low address bits ignored.
- index >= NUM_REGS -> DECERR (2'b11).
- Write to RO register -> SLVERR (2'b10), no state change.
- Otherwise OKAY (2'b00).

Reset (ARESETN low, asynchronous):
- All READY/VALID low; BRESP, RRESP, RDATA = 0.
- RW registers = RESET_VALUE; wr_pulse, rd_pulse = 0.
- Any transaction in flight is abandoned; no response is issued after release.
- READY outputs follow FSM state, so they are high from the first cycle ARESETN is high.

Write FSM states: W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP.
- AWREADY=1 in W_IDLE and W_HAVE_DATA. WREADY=1 in W_IDLE and W_HAVE_ADDR. Both 0 in W_RESP.
- AW and W may arrive in either order or the same cycle. Each is captured on its handshake.
- The edge that completes the second handshake commits the write:
  - each byte k with WSTRB[k]=1 is updated;
  - FSM moves to W_RESP;
  - BVALID=1 and BRESP valid in the next cycle, i.e. latency 1 after the last handshake;
  - wr_pulse[index]=1 for exactly that cycle, OKAY writes only.
- BVALID and BRESP hold until BREADY; on B handshake -> W_IDLE. Only one write outstanding.
- WSTRB=0 on a valid RW register: OKAY, no bytes change, wr_pulse still fires.

Read FSM states: R_IDLE, R_RESP.
- ARREADY=1 only in R_IDLE.
- On AR handshake, RDATA/RRESP are registered and RVALID=1 next cycle (latency 1).
  - RDATA = RW register value, or reg_in slice sampled at the handshake edge for RO registers.
  - DECERR returns RDATA=0.
- rd_pulse[index] one cycle coincident with RVALID rising, OKAY reads only.
- RDATA/RRESP/RVALID held stable until RREADY; on R handshake -> R_IDLE.

Concurrency:
- Read and write channels are fully independent.
- An AR handshake on the same edge as a write commit to the same register returns the pre-write value.

Test Plan:
1. Reset: ARESETN low 200 ns, then high -> every RW reg_out slice = RESET_VALUE; BVALID=RVALID=0. AW and W to addr 0x04, data 0x00000002 -> BRESP=00; read 0x04 returns 0x00000002.
2. W-before-AW: WVALID with 0xDEADBEEF three cycles before AWVALID addr 0x08 -> WREADY drops after W handshake; BVALID one cycle after AW handshake; reg 2 = 0xDEADBEEF; wr_pulse[2] high exactly one cycle.
3. Byte strobes: reg 3 = 0x11223344, write 0xAABBCCDD with WSTRB=4'b0101 -> reg 3 = 0x11BB33DD.
4. Errors: NUM_REGS=8, write to 0x20 -> BRESP=11, no register changes. RO_MASK bit 1 set, write 0x04 -> BRESP=10. reg_in slot 1 = 0xCAFE0001, read 0x04 -> RDATA=0xCAFE0001, RRESP=00. Read 0x3C -> RDATA=0, RRESP=11.
5. Backpressure and collision:
   - BREADY low 10 cycles -> BVALID and BRESP stable, AWREADY/WREADY stay 0.
   - Same-edge read of reg 0 (0x00000001) during write 0x5 -> RDATA=0x00000001; subsequent read returns 0x5.
6. Reset mid-write: AW accepted, ARESETN pulsed low before W -> no BVALID after release, registers back to RESET_VALUE. Next full write/read at DATA_WIDTH=64 succeeds with OKAY.
